// File: rtl/countdown_ctrl.sv
// Two-digit BCD seconds countdown: loads 00-99, decrements once per sec_pulse while running, flags expiry.
// Latency: every state/count/output change is visible one cycle after the sampling edge.
// Flow control: strobe-driven with no handshake; timer_en gates the upstream secTimer and is high only in RUN.
module countdown_ctrl #(
  parameter logic [3:0] INIT_TENS = 4'd9,
  parameter logic [3:0] INIT_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_pulse,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  output logic       timer_en,
  output logic [3:0] tens_bcd,
  output logic [3:0] ones_bcd,
  output logic       timeout,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  logic count_zero;
  logic count_one;

  // Non-BCD digits from the load port saturate at 9 so the count never exceeds 99.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Count comparisons used by the FSM; both are decoded from registered digits only.
  always_comb begin
    count_zero = (tens_bcd == 4'd0) && (ones_bcd == 4'd0);
    count_one  = (tens_bcd == 4'd0) && (ones_bcd == 4'd1);
  end

  // Control FSM with registered count and outputs; priority is reset > load > pause > start > sec_pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tens_bcd <= INIT_TENS;
      ones_bcd <= INIT_ONES;
      timer_en <= 1'b0;
      timeout  <= 1'b0;
      done     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (load) begin
        // Load overrides everything else and parks the counter in IDLE.
        tens_bcd <= clamp_digit(load_tens);
        ones_bcd <= clamp_digit(load_ones);
        state    <= IDLE;
        timer_en <= 1'b0;
        done     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A zero count cannot start; pause beats a coincident start.
            if (!pause && start && !count_zero) begin
              state    <= RUN;
              timer_en <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state    <= PAUSE;
              timer_en <= 1'b0;
            end else if (sec_pulse && !count_zero) begin
              if (ones_bcd == 4'd0) begin
                ones_bcd <= 4'd9;
                tens_bcd <= tens_bcd - 4'd1;
              end else begin
                ones_bcd <= ones_bcd - 4'd1;
              end
              // Reaching 00 expires the countdown: timeout pulses as done rises.
              if (count_one) begin
                state    <= DONE;
                timer_en <= 1'b0;
                done     <= 1'b1;
                timeout  <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (!pause && start) begin
              state    <= RUN;
              timer_en <= 1'b1;
            end
          end
          DONE: begin
            // Terminal until load or reset.
            state <= DONE;
          end
          default: begin
            state    <= IDLE;
            timer_en <= 1'b0;
            done     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus random strobes.
// Reference keeps the count as a plain integer 0..99 and a few mode flags.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_countdown_ctrl;

  logic       clk;
  logic       rst;
  logic       sec_pulse;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic       timer_en;
  logic [3:0] tens_bcd;
  logic [3:0] ones_bcd;
  logic       timeout;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_cnt;
  bit m_running;
  bit m_paused;
  bit m_expired;
  bit m_timeout;

  countdown_ctrl #(.INIT_TENS(4'd9), .INIT_ONES(4'd9)) dut (
    .clk       (clk),
    .rst       (rst),
    .sec_pulse (sec_pulse),
    .load      (load),
    .load_tens (load_tens),
    .load_ones (load_ones),
    .start     (start),
    .pause     (pause),
    .timer_en  (timer_en),
    .tens_bcd  (tens_bcd),
    .ones_bcd  (ones_bcd),
    .timeout   (timeout),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural update of the reference for one clock edge.
  task automatic model_edge(input bit r, input bit ld, input int lt, input int lo,
                            input bit st, input bit ps, input bit sp);
    if (!r) begin
      m_cnt = 99; m_running = 0; m_paused = 0; m_expired = 0; m_timeout = 0;
    end else begin
      m_timeout = 0;
      if (ld) begin
        m_cnt = ((lt > 9) ? 9 : lt) * 10 + ((lo > 9) ? 9 : lo);
        m_running = 0; m_paused = 0; m_expired = 0;
      end else if (m_expired) begin
        // terminal
      end else if (m_running) begin
        if (ps) begin
          m_running = 0; m_paused = 1;
        end else if (sp && m_cnt > 0) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_running = 0; m_expired = 1; m_timeout = 1;
          end
        end
      end else if (m_paused) begin
        if (!ps && st) begin m_running = 1; m_paused = 0; end
      end else begin
        if (!ps && st && m_cnt != 0) m_running = 1;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare every output.
  task automatic step(input bit r, input bit ld, input int lt, input int lo,
                      input bit st, input bit ps, input bit sp);
    rst = r; load = ld; load_tens = lt[3:0]; load_ones = lo[3:0];
    start = st; pause = ps; sec_pulse = sp;
    @(posedge clk);
    model_edge(r, ld, lt, lo, st, ps, sp);
    #1;
    chk("tens", int'(tens_bcd), m_cnt / 10);
    chk("ones", int'(ones_bcd), m_cnt % 10);
    chk("timer_en", int'(timer_en), int'(m_running));
    chk("done", int'(done), int'(m_expired));
    chk("timeout", int'(timeout), int'(m_timeout));
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; sec_pulse = 1'b0;
  endtask

  task automatic idle_step();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_digits(input string tag, input int t, input int o);
    chk({tag, "_tens"}, int'(tens_bcd), t);
    chk({tag, "_ones"}, int'(ones_bcd), o);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
    start = 1'b0; pause = 1'b0; sec_pulse = 1'b0;
    m_cnt = 0; m_running = 0; m_paused = 0; m_expired = 0; m_timeout = 0;
    #2;

    // Reset
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    expect_digits("reset", 9, 9);
    chk("reset_timer_en", int'(timer_en), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_timeout", int'(timeout), 0);

    // Load 12, run three seconds with a tens borrow
    step(1, 1, 1, 2, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("run_timer_en", int'(timer_en), 1);
    step(1, 0, 0, 0, 0, 0, 1); expect_digits("dec1", 1, 1);
    step(1, 0, 0, 0, 0, 0, 1); expect_digits("dec2", 1, 0);
    step(1, 0, 0, 0, 0, 0, 1); expect_digits("borrow", 0, 9);
    chk("borrow_timer_en", int'(timer_en), 1);

    // Expiry from 02
    step(1, 1, 0, 2, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1); expect_digits("exp1", 0, 1);
    step(1, 0, 0, 0, 0, 0, 1); expect_digits("exp0", 0, 0);
    chk("exp_timeout", int'(timeout), 1);
    chk("exp_done", int'(done), 1);
    chk("exp_timer_en", int'(timer_en), 0);
    idle_step();
    chk("timeout_one_cycle", int'(timeout), 0);
    step(1, 0, 0, 0, 1, 1, 1); expect_digits("done_hold", 0, 0);
    chk("done_hold_done", int'(done), 1);

    // Pause at 05
    step(1, 1, 0, 5, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1); expect_digits("pause_sec", 0, 5);
    chk("pause_timer_en", int'(timer_en), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1);
    expect_digits("paused_hold", 0, 5);
    step(1, 0, 0, 0, 1, 1, 0);
    chk("pause_wins", int'(timer_en), 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1); expect_digits("resume", 0, 4);

    // Load corner cases
    step(1, 1, 3, 12, 0, 0, 0); expect_digits("clamp", 3, 9);
    step(1, 1, 15, 15, 0, 0, 0); expect_digits("clamp_both", 9, 9);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("zero_start_timer_en", int'(timer_en), 0);
    chk("zero_start_timeout", int'(timeout), 0);
    step(1, 1, 1, 5, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 2, 3, 0, 0, 1); expect_digits("load_over_sec", 2, 3);
    chk("load_over_sec_timer_en", int'(timer_en), 0);

    // Mid-run reset
    step(1, 1, 4, 7, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0, 1); expect_digits("midrun_rst", 9, 9);
    chk("midrun_rst_timer_en", int'(timer_en), 0);

    // Random strobes against the reference
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, st, ps, sp;
      int lt, lo;
      r  = ($urandom_range(0, 99) != 0);
      ld = ($urandom_range(0, 19) == 0);
      lt = (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)));
      lo = int'($urandom_range(0, 15));
      st = ($urandom_range(0, 5) == 0);
      ps = ($urandom_range(0, 11) == 0);
      sp = ($urandom_range(0, 2) == 0);
      step(r, ld, lt, lo, st, ps, sp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
